// File: rtl/console_pkg.sv
`default_nettype none
// ============================================================================
// Module  : console_pkg
// Brief   : Shared types and constants for the console UART paths.
// Revision: 1.0 - initial release
// ============================================================================
package console_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

endpackage : console_pkg
`default_nettype wire

// File: rtl/console_uart_tx_baud_tick.sv
`default_nettype none
// ============================================================================
// Module  : baud_tick
// Brief   : Free-running bit-period counter with synchronous clear and a
//           terminal-count flag; wraps to zero on terminal count.
// Revision: 1.0 - initial release
// ============================================================================
module baud_tick #(
    parameter int CLKS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tc
);

    localparam int              CNT_W        = (CLKS > 1) ? $clog2(CLKS) : 1;
    localparam logic [CNT_W-1:0] c_last_count = CNT_W'(CLKS - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear || o_tc) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tc = (r_count == c_last_count);

endmodule : baud_tick
`default_nettype wire

// File: rtl/console_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : console_uart_tx
// Brief   : Drains the console FIFO onto a UART TX line (8N1, LSB first,
//           gapless frames). Define CONSOLE_UART_TX_PARITY_EN for 8E1.
// Revision: 1.0 - initial release
// ============================================================================
module console_uart_tx
    import console_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       data_avail,
    input  logic [7:0] data_in,
    output logic       adv,
    output logic       tx,
    output logic       busy
);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("console_uart_tx: CLKS_PER_BIT must be within 4..65535");
    end

    localparam logic [2:0] c_last_bit = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t r_state, w_state_next;
    logic [7:0]     r_shreg, w_shreg_next;
    logic [2:0]     r_bitcnt, w_bitcnt_next;
    logic           r_adv, r_tx, r_busy;
    logic           w_adv_next, w_tx_next, w_busy_next;
    logic           w_tc;
    logic           w_can_load;
    logic           w_load;
`ifdef CONSOLE_UART_TX_PARITY_EN
    logic           r_parity, w_parity_next;
`endif

    baud_tick #(
        .CLKS    (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (r_state == ST_IDLE),
        .o_tc    (w_tc)
    );

    assign w_can_load = en && data_avail;

    always_comb begin
        w_state_next  = r_state;
        w_shreg_next  = r_shreg;
        w_bitcnt_next = r_bitcnt;
        w_load        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_load = w_can_load;
            end
            ST_START: begin
                if (w_tc) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_tc) begin
                    w_shreg_next  = {1'b0, r_shreg[7:1]};
                    w_bitcnt_next = r_bitcnt + 3'd1;
                    if (r_bitcnt == c_last_bit) begin
`ifdef CONSOLE_UART_TX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef CONSOLE_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tc) w_state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                // Last stop cycle doubles as the load slot so frames chain gaplessly.
                if (w_tc) begin
                    if (w_can_load) w_load = 1'b1;
                    else            w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_state_next  = ST_START;
            w_shreg_next  = data_in;
            w_bitcnt_next = 3'd0;
        end

`ifdef CONSOLE_UART_TX_PARITY_EN
        w_parity_next = w_load ? ^data_in : r_parity;
`endif

        // Outputs are derived from next-state values so they can be registered.
        w_adv_next  = w_load;
        w_busy_next = (w_state_next != ST_IDLE);
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shreg_next[0];
`ifdef CONSOLE_UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = w_parity_next;
`endif
            default:   w_tx_next = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_adv    <= 1'b0;
            r_tx     <= UART_IDLE_LEVEL;
            r_busy   <= 1'b0;
`ifdef CONSOLE_UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_shreg  <= w_shreg_next;
            r_bitcnt <= w_bitcnt_next;
            r_adv    <= w_adv_next;
            r_tx     <= w_tx_next;
            r_busy   <= w_busy_next;
`ifdef CONSOLE_UART_TX_PARITY_EN
            r_parity <= w_parity_next;
`endif
        end
    end

    assign adv  = r_adv;
    assign tx   = r_tx;
    assign busy = r_busy;

endmodule : console_uart_tx
`default_nettype wire

// File: tb/tb_console_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_console_uart_tx
// Brief   : Directed plus random stimulus against a line-level frame model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_console_uart_tx;

    localparam int CPB = 4;
`ifdef CONSOLE_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       en         = 1'b0;
    logic       data_avail = 1'b0;
    logic [7:0] data_in    = 8'h00;
    logic       adv, tx, busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] fifo[$];
    logic       exp_q[$];
    logic       exp_adv   = 1'b0;
    int         adv_count = 0;
    int         busy_cyc  = 0;

    console_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data_avail (data_avail),
        .data_in    (data_in),
        .adv        (adv),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic upd_fifo();
        data_avail = (fifo.size() > 0);
        data_in    = data_avail ? fifo[0] : 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
        upd_fifo();
    endtask

    // Expected line levels for one whole frame, one entry per clock.
    task automatic push_frame(input logic [7:0] b);
        for (int k = 0; k < FRAME_BITS; k++) begin
            logic lvl;
            if (k == 0)                             lvl = 1'b0;
            else if (k <= 8)                        lvl = b[k-1];
            else if (k == 9 && FRAME_BITS == 11)    lvl = ^b;
            else                                    lvl = 1'b1;
            for (int c = 0; c < CPB; c++) exp_q.push_back(lvl);
        end
    endtask

    task automatic tick();
        logic load;
        load = rst_n && (exp_q.size() <= 1) && en && data_avail;
        if (!rst_n)                exp_q.delete();
        else if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (load) push_frame(data_in);
        exp_adv = load;
        @(posedge clk);
        #1;
        check_bit("adv",  adv,  exp_adv);
        check_bit("busy", busy, exp_q.size() > 0);
        check_bit("tx",   tx,   (exp_q.size() > 0) ? exp_q[0] : 1'b1);
        if (adv === 1'b1) begin
            adv_count++;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        if (busy === 1'b1) busy_cyc++;
        upd_fifo();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset, then idle line with empty FIFO
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        en    = 1'b1;
        adv_count = 0;
        busy_cyc  = 0;
        run(50);
        check_int("idle_adv_count", adv_count, 0);
        check_int("idle_busy_cycles", busy_cyc, 0);

        // Single frame 0xAB
        push_byte(8'hAB);
        run(CPB * FRAME_BITS + 10);
        check_int("single_adv_count", adv_count, 1);
        check_int("single_frame_len", busy_cyc, CPB * FRAME_BITS);

        // Back-to-back 0x55, 0x0F
        push_byte(8'h55);
        push_byte(8'h0F);
        busy_cyc = 0;
        run(2 * CPB * FRAME_BITS + 10);
        check_int("b2b_adv_count", adv_count, 3);
        check_int("b2b_busy_cycles", busy_cyc, 2 * CPB * FRAME_BITS);
        check_int("b2b_fifo_empty", fifo.size(), 0);

        // en dropped mid-frame with two bytes queued
        push_byte(8'h12);
        push_byte(8'h34);
        run(10);
        en = 1'b0;
        run(CPB * FRAME_BITS + 20);
        check_int("en_low_adv_count", adv_count, 4);
        check_int("en_low_fifo_depth", fifo.size(), 1);
        en = 1'b1;
        run(CPB * FRAME_BITS + 10);
        check_int("en_high_adv_count", adv_count, 5);

        // Reset during data bit 3 of 0xFF, with another byte waiting
        push_byte(8'hFF);
        run(1 + 4 * CPB + 1);
        push_byte(8'hC3);
        rst_n = 1'b0;
        run(5);
        check_int("rst_adv_count", adv_count, 6);
        rst_n = 1'b1;
        run(CPB * FRAME_BITS + 10);
        check_int("post_rst_adv_count", adv_count, 7);

        // Randomized traffic with occasional en drops and resets
        for (int i = 0; i < 600; i++) begin
            if (fifo.size() < 4 && $urandom_range(0, 5) == 0)
                push_byte(8'($urandom));
            en    = ($urandom_range(0, 9) != 0);
            rst_n = ($urandom_range(0, 249) != 0);
            tick();
        end
        rst_n = 1'b1;
        en    = 1'b1;
        run(6 * CPB * FRAME_BITS);
        check_int("final_fifo_empty", fifo.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_console_uart_tx
`default_nettype wire

// File: doc/console_uart_tx.md
# console_uart_tx

Transmit-side drain for the console mux: pops bytes from the console FIFO's show-ahead read port (`data_avail` / `data_out` / `adv`) and serializes each one onto a UART TX line, 8 data bits, LSB first, one stop bit. It is the consumer end of the FIFO whose producer is the UART receiver path. Frames are sent back-to-back with no idle gap while data is available and the block is enabled.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal range is 4 to 65535; elaboration fails outside it.

Ports:
- `clk` in, 1 bit: single clock; all logic is on the rising edge.
- `rst_n` in, 1 bit: synchronous, active-low reset.
- `en` in, 1 bit: permits the start of new frames. A frame already in flight always completes.
- `data_avail` in, 1 bit: the FIFO holds at least one byte.
- `data_in` in, 8 bits: FIFO head byte, valid while `data_avail`=1.
- `adv` out, 1 bit: one-cycle pulse that pops the FIFO head.
- `tx` out, 1 bit: serial line, idle high.
- `busy` out, 1 bit: high from the start bit through the last stop-bit cycle.

## Operation
- States:
  - `IDLE`: `tx`=1, `busy`=0.
  - `START`: `tx`=0.
  - `DATA`: `tx`=`shreg[0]`.
  - `PARITY`: present only with the macro.
  - `STOP`: `tx`=1.
- Internal counters:
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits. It counts 0 to `CLKS_PER_BIT-1` in every non-IDLE state, and the state advances when it reaches `CLKS_PER_BIT-1`.
  - Bit counter: 3 bits, counts 0 to 7 in `DATA`.
  - Shift register: 8 bits, shifted right once per completed data bit.
- Load: if the state is IDLE, `en`=1 and `data_avail`=1 at a clock edge:
  - `data_in` is latched into the shift register.
  - Next state is START.
  - `adv` is registered high for exactly one cycle.
- Gapless chaining: on the last cycle of STOP, if `en`=1 and `data_avail`=1, the load happens with next state START. Otherwise the next state is IDLE.
- `adv` never pulses more than once per frame and never pulses while `data_avail`=0.
- `en` deasserted mid-frame: the current frame finishes, then the block goes to IDLE. No pop occurs.
- Reset (`rst_n`=0 at an edge), including mid-frame:
  - State returns to IDLE.
  - All counters and the shift register clear.
  - `tx`=1, `adv`=0, `busy`=0 from the next cycle.
  - A byte that was in flight is discarded; it was already popped.
- Reset values: `tx`=1, `adv`=0, `busy`=0.

## Timing
- The load decision is made at edge N:
  - `adv`=1, `busy`=1 and `tx`=0 (start bit) during cycle N+1.
  - `adv` returns to 0 at N+2.
- Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity.
- Back-to-back frames: the next start bit immediately follows the last stop-bit cycle, with zero idle cycles.
- The FIFO lowers `data_avail` within 2 cycles of `adv`. `CLKS_PER_BIT`≥4 guarantees this has happened before the block samples `data_avail` again.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- Macro: `CONSOLE_UART_TX_PARITY_EN`.
- Defined:
  - A PARITY state sits between DATA and STOP.
  - `tx` carries even parity, the XOR of the 8 data bits, computed at load.
  - Frame length is 11 bits.
- Undefined:
  - No PARITY state and no parity logic.
  - Frame length is 10 bits.

## Structure
- Shared package `console_pkg`:
  - State enum `uart_tx_state_t`.
  - Constants `UART_DATA_BITS=8` and `UART_IDLE_LEVEL=1'b1`.
- Sub-module `baud_tick`: parameterized counter with clear and terminal-count output, reusable by the receiver.
- State machine, shift register and bit counter live in `console_uart_tx`.

## Test plan
Scenarios 1–5 use `CLKS_PER_BIT`=4. Scenario 6 uses `CLKS_PER_BIT`=16.
1. Reset release with `data_avail`=0:
   - `tx`=1, `adv`=0 and `busy`=0 for 50 cycles.
2. Single frame: FIFO loaded with 0xAB, `en`=1.
   - Exactly one `adv` pulse.
   - `tx` sequence in 4-cycle bits: 0, 1,1,0,1,0,1,0,1, 1.
   - `busy` falls 40 cycles after the start bit begins.
3. Back-to-back: FIFO holds 0x55 then 0x0F.
   - Two `adv` pulses, 40 cycles apart.
   - Start bit of 0x0F immediately follows the stop bit of 0x55.
   - FIFO empty afterwards.
4. `en` dropped mid-frame with 0x12 and 0x34 queued:
   - 0x12 completes.
   - No second `adv` and `tx` stays 1.
   - After `en`=1 again, 0x34 is sent.
5. `rst_n`=0 during data bit 3 of 0xFF:
   - Next cycle `tx`=1, `busy`=0.
   - No further `adv` while reset is held.
6. Parity build with 0x07 at `CLKS_PER_BIT`=16:
   - Parity bit = 1.
   - Frame lasts 176 cycles.
